// File: rtl/bcd_seg_pkg.sv
// Shared definitions for the BCD-to-seven-segment encoder: FSM states and
// active-low segment patterns in {dp,g,f,e,d,c,b,a} order.
package bcd_seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Seven input bits need seven double-dabble iterations (cnt 0..6).
    localparam logic [2:0] LAST_ITER = 3'd6;

endpackage

// File: rtl/bcd_seg_encoder_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern (DP off).
module seg7_decode
    import bcd_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seg_encoder.sv
// Binary (0..99) to two-digit active-low seven-segment patterns using a
// sequential double-dabble conversion and a registered encode stage.
module bcd_seg_encoder
    import bcd_seg_pkg::*;
#(
    parameter bit         BLANK_LZ = 1'b1,
    parameter logic [1:0] DP_MASK  = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] value,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [7:0] led1,
    output logic [7:0] led2
);

    state_t      state, state_nx;
    logic [3:0]  tens, ones;
    logic [6:0]  bin;
    logic [2:0]  cnt;
    logic        ovf;
    logic        accept, step, encode;
    logic [3:0]  tens_adj, ones_adj;
    logic [7:0]  tens_seg, ones_seg;
    logic [7:0]  led1_nx, led2_nx;

    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST_ITER) state_nx = ENCODE;
            ENCODE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && load;
        step   = (state == SHIFT);
        encode = (state == ENCODE);
        busy   = (state != IDLE);
    end

    // Double-dabble: add-3 correction on each nibble, then shift the whole chain.
    assign tens_adj = dd_adjust(tens);
    assign ones_adj = dd_adjust(ones);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
            bin  <= 7'd0;
            cnt  <= 3'd0;
            ovf  <= 1'b0;
        end else if (accept) begin
            tens <= 4'd0;
            ones <= 4'd0;
            bin  <= value;
            cnt  <= 3'd0;
            ovf  <= (value > 7'd99);
        end else if (step) begin
            {tens, ones, bin} <= {tens_adj[2:0], ones_adj, bin, 1'b0};
            cnt               <= cnt + 3'd1;
        end
    end

    seg7_decode u_ones (.digit(ones), .seg(ones_seg));
    seg7_decode u_tens (.digit(tens), .seg(tens_seg));

    // Overflow shows "--" regardless of blanking; DP applies to every case.
    always_comb begin
        led1_nx = ovf ? SEG_DASH : ones_seg;
        if (ovf)
            led2_nx = SEG_DASH;
        else if (BLANK_LZ && (tens == 4'd0))
            led2_nx = SEG_BLANK;
        else
            led2_nx = tens_seg;
        if (DP_MASK[0]) led1_nx[7] = 1'b0;
        if (DP_MASK[1]) led2_nx[7] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led1 <= SEG_BLANK;
            led2 <= SEG_BLANK;
            done <= 1'b0;
        end else begin
            done <= encode;
            if (encode) begin
                led1 <= led1_nx;
                led2 <= led2_nx;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_encoder.sv
// Scoreboard bench for bcd_seg_encoder: two instances (default parameters and
// BLANK_LZ=0/DP_MASK=01) share stimulus; a monitor checks every cycle.
module tb_bcd_seg_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [6:0] value;
    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] led1_a, led2_a, led1_b, led2_b;

    typedef struct {
        logic [7:0] l2;
        logic [7:0] l1;
        int         due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   next_free = 0;
    int   acc_n = -100;
    bit   active = 1'b0;
    logic [15:0] hold_a = 16'hFFFF;
    logic [15:0] hold_b = 16'hFFFF;
    logic [7:0]  seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [6:0]  hold_vals [6] = '{7'd12, 7'd87, 7'd5, 7'd100, 7'd63, 7'd40};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_seg_encoder #(.BLANK_LZ(1'b1), .DP_MASK(2'b00)) dut_a (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_a), .done(done_a), .led1(led1_a), .led2(led2_a)
    );

    bcd_seg_encoder #(.BLANK_LZ(1'b0), .DP_MASK(2'b01)) dut_b (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_b), .done(done_b), .led1(led1_b), .led2(led2_b)
    );

    function automatic logic [15:0] model(input int v, input bit blz, input logic [1:0] dp);
        logic [7:0] l2, l1;
        if (v > 99) begin
            l2 = 8'hBF;
            l1 = 8'hBF;
        end else begin
            l1 = seg_tbl[v % 10];
            l2 = ((v / 10) == 0 && blz) ? 8'hFF : seg_tbl[v / 10];
        end
        if (dp[1]) l2[7] = 1'b0;
        if (dp[0]) l1[7] = 1'b0;
        return {l2, l1};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge where the next rising edge accepts the load.
    task automatic accept_now(input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        acc_n     = cyc + 1;
        next_free = acc_n + 9;
        active    = 1'b1;
        e.due = acc_n + 8;
        e.l2 = ea[15:8]; e.l1 = ea[7:0]; qa.push_back(e);
        e.l2 = eb[15:8]; e.l1 = eb[7:0]; qb.push_back(e);
    endtask

    task automatic issue_exp(input int v, input logic [15:0] ea, input logic [15:0] eb);
        @(negedge clk);
        while (cyc + 1 < next_free) @(negedge clk);
        value = 7'(v);
        load  = 1'b1;
        accept_now(ea, eb);
        @(negedge clk);
        load  = 1'b0;
        value = 7'($urandom_range(0, 127));
    endtask

    task automatic issue(input int v);
        issue_exp(v, model(v, 1'b1, 2'b00), model(v, 1'b0, 2'b01));
    endtask

    // Monitor: done/leds/busy of both instances every cycle, #1 after the edge.
    initial begin
        exp_t       e;
        logic [7:0] da, db, eb;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                hold_a = 16'hFFFF;
                hold_b = 16'hFFFF;
                chk("done_a_rst", {7'b0, done_a}, 8'd0);
                chk("done_b_rst", {7'b0, done_b}, 8'd0);
                chk("busy_a_rst", {7'b0, busy_a}, 8'd0);
            end else begin
                da = 8'd0;
                db = 8'd0;
                if (qa.size() > 0 && qa[0].due == cyc) begin
                    e = qa.pop_front();
                    hold_a = {e.l2, e.l1};
                    da = 8'd1;
                end
                if (qb.size() > 0 && qb[0].due == cyc) begin
                    e = qb.pop_front();
                    hold_b = {e.l2, e.l1};
                    db = 8'd1;
                end
                eb = (active && cyc >= acc_n && cyc <= acc_n + 7) ? 8'd1 : 8'd0;
                chk("done_a", {7'b0, done_a}, da);
                chk("done_b", {7'b0, done_b}, db);
                chk("busy_a", {7'b0, busy_a}, eb);
                chk("busy_b", {7'b0, busy_b}, eb);
            end
            chk("led1_a", led1_a, hold_a[7:0]);
            chk("led2_a", led2_a, hold_a[15:8]);
            chk("led1_b", led1_b, hold_b[7:0]);
            chk("led2_b", led2_b, hold_b[15:8]);
        end
    end

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 7'd0;
        repeat (3) @(negedge clk);
        chk("reset_led1", led1_a, 8'hFF);
        chk("reset_led2", led2_a, 8'hFF);
        chk("reset_busy", {7'b0, busy_a}, 8'd0);
        chk("reset_done", {7'b0, done_a}, 8'd0);
        rst = 1'b0;

        // Hand-computed directed vectors: {led2,led1} for instance a and b.
        issue_exp(42,  16'h99A4, 16'h9924);
        issue_exp(7,   16'hFFF8, 16'hC078);
        issue_exp(0,   16'hFFC0, 16'hC040);
        issue_exp(99,  16'h9090, 16'h9010);
        issue_exp(100, 16'hBFBF, 16'hBF3F);
        issue_exp(127, 16'hBFBF, 16'hBF3F);
        issue_exp(35,  16'hB092, 16'hB012);

        // load held high with value changing every cycle.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            value = hold_vals[k % 6];
            load  = 1'b1;
            if (cyc + 1 >= next_free)
                accept_now(model(int'(value), 1'b1, 2'b00), model(int'(value), 1'b0, 2'b01));
        end
        @(negedge clk);
        load = 1'b0;

        // Reset in the middle of a conversion of 55.
        issue_exp(55, 16'h9292, 16'h9212);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        active    = 1'b0;
        next_free = 0;
        #1;
        chk("abort_led1", led1_a, 8'hFF);
        chk("abort_led2", led2_a, 8'hFF);
        chk("abort_busy", {7'b0, busy_a}, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue_exp(55, 16'h9292, 16'h9212);

        for (int v = 0; v < 128; v++) issue(v);

        repeat (12) @(negedge clk);
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending a=%0d b=%0d expected 0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
